video_capture: RTL

Frame-grab block for the Pocket RISC-V core: samples an 8-bit pixel stream with single-cycle sync pulses and a data-enable, crops it to a programmable window, optionally decimates 2x2, and queues captured pixels in a FIFO. The CPU drains the FIFO over the same byte-register bus used by the video output block. Typical use is loopback capture of that block's output, or an external pixel source, into software.

---
 rtl/video_capture.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/video_capture.sv
// video_capture: crops an 8-bit pixel stream to a programmable window and
// queues the captured pixels in a FIFO that the CPU drains over the byte
// register bus.
// Optional feature macro: VIDEO_CAPTURE_DECIMATE_EN keeps only pixels at even
// offsets from the window start on both axes (2x2 decimation).
module video_capture #(
   parameter int PORT_WIDTH        = 32,
   parameter int BUS_ADDR_DATA_LEN = 8,
   parameter int BASE_ADDR         = 'h00,
   parameter int FIFO_DEPTH        = 64,
   parameter int PIXEL             = 'h00,
   parameter int WIN_START_X_H     = 'h01,
   parameter int WIN_START_X_L     = 'h02,
   parameter int WIN_END_X_H       = 'h03,
   parameter int WIN_END_X_L       = 'h04,
   parameter int WIN_START_Y_H     = 'h05,
   parameter int WIN_START_Y_L     = 'h06,
   parameter int WIN_END_Y_H       = 'h07,
   parameter int WIN_END_Y_L       = 'h08,
   parameter int ACTION            = 'h09,
   parameter int STATUS            = 'h0A,
   parameter int LEVEL             = 'h0B
) (
   input  logic                         clk_core_i,
   input  logic                         rst_i,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
   input  logic                         wrb_i,
   input  logic [PORT_WIDTH-1:0]        bus_i,
   input  logic                         rdb_i,
   output logic [PORT_WIDTH-1:0]        bus_o,
   input  logic                         v_sync_i,
   input  logic                         h_sync_i,
   input  logic                         video_en_i,
   input  logic [7:0]                   video_i
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   localparam int AW    = BUS_ADDR_DATA_LEN;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [AW-1:0] A_PIXEL = AW'(BASE_ADDR + PIXEL);
   localparam logic [AW-1:0] A_SXH   = AW'(BASE_ADDR + WIN_START_X_H);
   localparam logic [AW-1:0] A_SXL   = AW'(BASE_ADDR + WIN_START_X_L);
   localparam logic [AW-1:0] A_EXH   = AW'(BASE_ADDR + WIN_END_X_H);
   localparam logic [AW-1:0] A_EXL   = AW'(BASE_ADDR + WIN_END_X_L);
   localparam logic [AW-1:0] A_SYH   = AW'(BASE_ADDR + WIN_START_Y_H);
   localparam logic [AW-1:0] A_SYL   = AW'(BASE_ADDR + WIN_START_Y_L);
   localparam logic [AW-1:0] A_EYH   = AW'(BASE_ADDR + WIN_END_Y_H);
   localparam logic [AW-1:0] A_EYL   = AW'(BASE_ADDR + WIN_END_Y_L);
   localparam logic [AW-1:0] A_ACT   = AW'(BASE_ADDR + ACTION);
   localparam logic [AW-1:0] A_STAT  = AW'(BASE_ADDR + STATUS);
   localparam logic [AW-1:0] A_LVL   = AW'(BASE_ADDR + LEVEL);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   state_t           state;
   logic             ovf;
   logic [9:0]       x, y, x_inc, y_inc;
   logic             en_q, en_fall;
   logic [9:0]       start_x, end_x, start_y, end_y;
   logic             in_win, dec_ok, capture;
   logic             cap_q;
   logic [7:0]       pix_q;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             empty, full;
   logic             pix_rd, pix_rd_q, pop, push_ok, overflow;
   logic             arm, abort, flush;
   logic [PORT_WIDTH-1:0] rdata;
   logic             unused_bits;

   assign unused_bits = ^{bus_i[PORT_WIDTH-1:8], h_sync_i};

   assign arm    = wrb_i && (addr_i == A_ACT) && (bus_i[7:0] == 8'h01);
   assign abort  = wrb_i && (addr_i == A_ACT) && (bus_i[7:0] == 8'h02);
   assign flush  = arm || abort;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign pix_rd   = rdb_i && (addr_i == A_PIXEL);
   assign pop      = pix_rd && !pix_rd_q && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok  = cap_q && (!full || pop);
   assign overflow = cap_q && full && !pop;

   assign x_inc   = (x == 10'd1023) ? x : x + 10'd1;
   assign y_inc   = (y == 10'd1023) ? y : y + 10'd1;
   assign en_fall = en_q && !video_en_i;

   // Window hit and optional decimation for the pixel on the inputs now.
   always_comb begin
      in_win = (x >= start_x) && (x <= end_x) && (y >= start_y) && (y <= end_y);
`ifdef VIDEO_CAPTURE_DECIMATE_EN
      dec_ok = ((x[0] ^ start_x[0]) == 1'b0) && ((y[0] ^ start_y[0]) == 1'b0);
`else
      dec_ok = 1'b1;
`endif
      capture = (state == S_CAPTURE) && video_en_i && in_win && dec_ok;
   end

   // Pixel coordinate counters.
   always_ff @(posedge clk_core_i or posedge rst_i) begin
      if (rst_i) begin
         x    <= '0;
         y    <= '0;
         en_q <= 1'b0;
      end else begin
         en_q <= video_en_i;
         x    <= video_en_i ? x_inc : '0;
         if (v_sync_i)
            y <= '0;
         else if (en_fall)
            y <= y_inc;
      end
   end

   // Input register stage; a flush cancels the pixel being sampled.
   always_ff @(posedge clk_core_i or posedge rst_i) begin
      if (rst_i) begin
         cap_q    <= 1'b0;
         pix_q    <= '0;
         pix_rd_q <= 1'b0;
      end else begin
         cap_q    <= capture && !flush;
         pix_q    <= video_i;
         pix_rd_q <= pix_rd;
      end
   end

   // Capture state machine with sticky overflow flag.
   always_ff @(posedge clk_core_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         ovf   <= 1'b0;
      end else if (arm) begin
         state <= S_ARMED;
         ovf   <= 1'b0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_ARMED:   if (v_sync_i) state <= S_CAPTURE;
            S_CAPTURE: begin
               if (v_sync_i)
                  state <= S_DONE;
               else if (en_fall && (y_inc > end_y))
                  state <= S_DONE;
            end
            default: ;
         endcase
         if (overflow)
            ovf <= 1'b1;
      end
   end

   // Window registers; a START write also loads the matching END half.
   always_ff @(posedge clk_core_i or posedge rst_i) begin
      if (rst_i) begin
         start_x <= '0;
         start_y <= '0;
         end_x   <= 10'd799;
         end_y   <= 10'd719;
      end else if (wrb_i) begin
         case (addr_i)
            A_SXH: begin start_x[9:8] <= bus_i[1:0]; end_x[9:8] <= bus_i[1:0]; end
            A_SXL: begin start_x[7:0] <= bus_i[7:0]; end_x[7:0] <= bus_i[7:0]; end
            A_EXH: end_x[9:8] <= bus_i[1:0];
            A_EXL: end_x[7:0] <= bus_i[7:0];
            A_SYH: begin start_y[9:8] <= bus_i[1:0]; end_y[9:8] <= bus_i[1:0]; end
            A_SYL: begin start_y[7:0] <= bus_i[7:0]; end_y[7:0] <= bus_i[7:0]; end
            A_EYH: end_y[9:8] <= bus_i[1:0];
            A_EYL: end_y[7:0] <= bus_i[7:0];
            default: ;
         endcase
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_core_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // FIFO storage.
   always_ff @(posedge clk_core_i) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= pix_q;
   end

   // Register read mux.
   always_comb begin
      rdata = '0;
      if (rdb_i) begin
         case (addr_i)
            A_PIXEL: rdata = empty ? '0 : PORT_WIDTH'(mem[rd_ptr]);
            A_SXH:   rdata = PORT_WIDTH'(start_x[9:8]);
            A_SXL:   rdata = PORT_WIDTH'(start_x[7:0]);
            A_EXH:   rdata = PORT_WIDTH'(end_x[9:8]);
            A_EXL:   rdata = PORT_WIDTH'(end_x[7:0]);
            A_SYH:   rdata = PORT_WIDTH'(start_y[9:8]);
            A_SYL:   rdata = PORT_WIDTH'(start_y[7:0]);
            A_EYH:   rdata = PORT_WIDTH'(end_y[9:8]);
            A_EYL:   rdata = PORT_WIDTH'(end_y[7:0]);
            A_STAT:  rdata = PORT_WIDTH'({state == S_DONE, ovf, full, empty,
                                          (state == S_ARMED) || (state == S_CAPTURE)});
            A_LVL:   rdata = PORT_WIDTH'(count);
            default: rdata = '0;
         endcase
      end
   end

   assign bus_o = rdata;

endmodule
